imem_fetch_responder: RTL and testbench
=======================================

Name: imem_fetch_responder

Overview:
- Instruction-memory responder on the far side of the program counter.
- Accepts the fetch address the PC presents and returns the instruction word after a programmable read latency.
- Drives the PC's hold control (stall = 1 means hold) for as long as a fetch is in flight.
- Sits between the PC register and the IF/ID stage; the branch unit's redirect drives its flush input.

Parameters:
- DATA_W, 32, instruction width.
- DEPTH_WORDS, 256, memory depth in words; power of two.
- READ_LAT, 2, cycles from request acceptance to instr_valid; must be >= 1.
- NOP_WORD, 32'h00000000, word returned on address error.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- pc_addr  in  32  byte address from the PC output.
- fetch_req  in  1  pc_addr is valid and a fetch is wanted.
- flush  in  1  branch redirect; discards any in-flight fetch.
- wr_en  in  1  program-load write strobe.
- wr_addr  in  32  program-load byte address; word-indexed, bits [1:0] ignored.
- wr_data  in  DATA_W  program-load data.
- instr  out  DATA_W  returned instruction; registered.
- instr_valid  out  1  one-cycle pulse, instr is new.
- addr_err  out  1  qualifies instr_valid: misaligned or out-of-range fetch.
- stall  out  1  to the PC control input; 1 = hold PC.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; instr = 0; instr_valid = 0; addr_err = 0; latency counter = 0.
  - stall = 0 while in reset.
  - Memory contents are not reset.
  - Reset asserted mid-fetch aborts the fetch; no response is ever produced for it.
- Word index = pc_addr[log2(DEPTH_WORDS)+1 : 2].
- Error conditions:
  - Misaligned: pc_addr[1:0] != 0.
  - Out of range: any pc_addr bit above the index field set.
- States: IDLE, WAIT, RESP.
- IDLE:
  - fetch_req=1 and flush=0 in cycle T: accept. Latch the word index and error flag; counter = READ_LAT-1.
  - Next state is WAIT if READ_LAT > 1, otherwise RESP.
  - fetch_req=0 or flush=1: stay in IDLE.
- WAIT:
  - Counter decrements each cycle. On the cycle it reads 1, the next state is RESP.
  - flush=1: go to IDLE immediately; no response is produced.
- RESP:
  - instr_valid=1 for exactly this cycle, with instr = mem[latched index], or NOP_WORD with addr_err=1 if the error flag is set.
  - Next state is always IDLE; fetch_req is ignored in RESP, since the PC has not yet advanced.
  - flush=1 in the RESP cycle: instr_valid and addr_err are forced 0 and instr keeps its old value.
- Timing:
  - Accepted at T gives instr_valid at T+READ_LAT.
  - One fetch per READ_LAT+1 cycles maximum.
- stall is combinational: (IDLE and fetch_req and !flush) or WAIT.
  - It is therefore 1 in cycles T through T+READ_LAT-1 and 0 in the RESP cycle, so the PC advances on the edge that ends RESP.
- instr holds its last value between responses. addr_err is 0 whenever instr_valid is 0.
- Memory read and write:
  - Memory is read on the edge entering RESP.
  - A write to the same word on that same edge is not seen (read-before-write).
  - Any earlier write is seen.
  - wr_en is accepted in every state; writes to out-of-range addresses are dropped.

Decomposition:
- Package imem_pkg:
  - fetch_state_t enum {IDLE, WAIT, RESP}.
  - NOP constant.
  - Index-width function (clog2 of DEPTH_WORDS).
- Counter width is clog2(READ_LAT+1).
- One sub-module, imem_array: single-port, synchronous-read RAM with an independent write port and read-before-write semantics.

Test Plan:
- Directed scenarios:
  - Load mem[0..3] = 11111111, 22222222, 33333333, 44444444. With READ_LAT=2, fetch_req at addr 0x4 -> stall=1 for 2 cycles, instr_valid at T+2, instr=22222222, addr_err=0.
  - Back-to-back: PC steps 0x0, 0x4, 0x8 with PC advance gated by stall -> three pulses 3 cycles apart, instr 11111111, 22222222, 33333333.
  - flush in the WAIT cycle of a fetch to 0xC -> no instr_valid, stall drops the next cycle, instr unchanged.
  - Fetch addr 0x6 (misaligned) and 0x400 (out of range, DEPTH 256) -> instr=00000000, addr_err=1 together with instr_valid.
  - rst_n pulsed low mid-WAIT -> all outputs 0 immediately, no response afterward. A write on the RESP edge to the word being fetched returns the old data.
- Parameter sweep: rerun the first two scenarios with READ_LAT=1 and READ_LAT=4 -> pulse spacing of 2 and 5 cycles respectively.

Source files
------------

// File: rtl/imem_fetch_responder_pkg.sv
// Shared types and helpers for the instruction-memory fetch responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } fetch_state_t;

  // Word returned in place of memory data when a fetch address is bad.
  localparam logic [31:0] NOP = 32'h0000_0000;

  // Width of the word-index field for a memory of the given depth.
  function automatic int idx_w(input int depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/imem_fetch_responder_if.sv
// Fetch/program-load bus between the PC side (master) and the responder (slave).
// Latency: n/a (wiring only).
// Backpressure: stall from the slave holds the master's PC.
// Ports: pc_addr/fetch_req/flush request a fetch, wr_* load program words,
//        instr/instr_valid/addr_err return the fetched word, stall holds the PC.
interface imem_fetch_responder_if #(
  parameter int DATA_W = 32
);
  import imem_pkg::*;

  logic [31:0]       pc_addr;
  logic              fetch_req;
  logic              flush;
  logic              wr_en;
  logic [31:0]       wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              addr_err;
  logic              stall;

  modport master (
    output pc_addr, fetch_req, flush, wr_en, wr_addr, wr_data,
    input  instr, instr_valid, addr_err, stall
  );

  modport slave (
    input  pc_addr, fetch_req, flush, wr_en, wr_addr, wr_data,
    output instr, instr_valid, addr_err, stall
  );

endinterface

// File: rtl/imem_fetch_responder_array.sv
// Single-port synchronous-read RAM with an independent write port.
// Latency: read data valid the cycle after rd_en_i; reads return pre-write data.
// Backpressure: none; accepts a read and a write every cycle.
// Ports: clk_i clock; rd_en_i/rd_idx_i/rd_data_o read; wr_en_i/wr_idx_i/wr_data_i write.
module imem_array #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic              rd_en_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rd_data_q;

  // Both updates are non-blocking, so a same-edge write to the read word
  // is not visible in rd_data_q (read-before-write).
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_idx_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: accepts a PC fetch and returns the word.
// Latency: instr_valid READ_LAT cycles after acceptance; one fetch per READ_LAT+1 cycles.
// Backpressure: stall holds the PC from acceptance until the response cycle.
// Ports: clk, rst_n (async active-low), bus (slave side of imem_fetch_responder_if).
module imem_fetch_responder
  import imem_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                DEPTH_WORDS = 256,
  parameter int                READ_LAT    = 2,
  parameter logic [DATA_W-1:0] NOP_WORD    = DATA_W'(NOP)
) (
  input logic                  clk,
  input logic                  rst_n,
  imem_fetch_responder_if.slave bus
);

  localparam int IDX_W = idx_w(DEPTH_WORDS);
  localparam int CNT_W = $clog2(READ_LAT + 1);

  fetch_state_t      state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic              err_q;
  logic [DATA_W-1:0] instr_q;

  logic              accept;
  logic              fetch_err;
  logic [IDX_W-1:0]  pc_idx;
  logic              rd_en;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] resp_word;
  logic              resp_live;
  logic              wr_ok;
  logic              wr_addr_unused;

  assign pc_idx    = bus.pc_addr[IDX_W+1:2];
  assign fetch_err = (|bus.pc_addr[1:0]) || (|bus.pc_addr[31:IDX_W+2]);
  assign accept    = (state_q == IDLE) && bus.fetch_req && !bus.flush;

  // The RAM is read on the edge that enters RESP. With a single-cycle latency
  // that edge is the accept edge, so the index comes straight from the PC.
  assign rd_en  = (accept && (READ_LAT == 1)) ||
                  ((state_q == WAIT) && (cnt_q == CNT_W'(1)) && !bus.flush);
  assign rd_idx = (state_q == IDLE) ? pc_idx : idx_q;

  assign wr_ok          = bus.wr_en && !(|bus.wr_addr[31:IDX_W+2]);
  assign wr_addr_unused = ^bus.wr_addr[1:0];

  imem_array #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk_i     (clk),
    .rd_en_i   (rd_en),
    .rd_idx_i  (rd_idx),
    .rd_data_o (rd_data),
    .wr_en_i   (wr_ok),
    .wr_idx_i  (bus.wr_addr[IDX_W+1:2]),
    .wr_data_i (bus.wr_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      instr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            idx_q   <= pc_idx;
            err_q   <= fetch_err;
            cnt_q   <= CNT_W'(READ_LAT - 1);
            state_q <= (READ_LAT > 1) ? WAIT : RESP;
          end
        end
        WAIT: begin
          if (bus.flush) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_q <= RESP;
            end
          end
        end
        RESP: begin
          // fetch_req is ignored here: the PC only advances on this edge.
          state_q <= IDLE;
          if (!bus.flush) begin
            instr_q <= resp_word;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_word = err_q ? NOP_WORD : rd_data;

  // A flush in the response cycle cancels the pulse and leaves instr untouched.
  assign resp_live       = (state_q == RESP) && !bus.flush;
  assign bus.instr       = resp_live ? resp_word : instr_q;
  assign bus.instr_valid = resp_live;
  assign bus.addr_err    = resp_live && err_q;
  assign bus.stall       = rst_n && (accept || (state_q == WAIT));

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Self-checking bench: three responders (READ_LAT 1, 2, 4) checked in turn
// against a transaction-level model of the fetch protocol.
module tb_imem_fetch_responder;

  localparam int          DEPTH = 256;
  localparam logic [31:0] NOPW  = 32'h0000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] pc_addr_a   [3];
  logic        fetch_req_a [3];
  logic        flush_a     [3];
  logic        wr_en_a     [3];
  logic [31:0] wr_addr_a   [3];
  logic [31:0] wr_data_a   [3];
  logic [31:0] instr_a     [3];
  logic        instr_vld_a [3];
  logic        addr_err_a  [3];
  logic        stall_a     [3];

  for (genvar g = 0; g < 3; g++) begin : g_lane
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    imem_fetch_responder_if #(.DATA_W(32)) bus ();
    assign bus.pc_addr   = pc_addr_a[g];
    assign bus.fetch_req = fetch_req_a[g];
    assign bus.flush     = flush_a[g];
    assign bus.wr_en     = wr_en_a[g];
    assign bus.wr_addr   = wr_addr_a[g];
    assign bus.wr_data   = wr_data_a[g];
    assign instr_a[g]     = bus.instr;
    assign instr_vld_a[g] = bus.instr_valid;
    assign addr_err_a[g]  = bus.addr_err;
    assign stall_a[g]     = bus.stall;
    imem_fetch_responder #(
      .DATA_W(32), .DEPTH_WORDS(DEPTH), .READ_LAT(L), .NOP_WORD(NOPW)
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: one outstanding fetch (accept cycle, word, error)
  // plus a word array mirroring program loads.
  logic [31:0] mem_m [DEPTH];
  bit          p_act;
  int          p_t;
  int          p_idx;
  bit          p_err;
  logic [31:0] p_data;
  logic [31:0] hold_m;
  int          cyc;
  int          lane;
  int          lat;

  // What the DUT showed on its most recent pulse.
  int          seen_cyc;
  logic [31:0] seen_instr;
  logic        seen_err;
  int          n_vld;
  logic        last_stall;
  int          v_cyc [$];
  logic [31:0] v_ins [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s lane=%0d lat=%0d cyc=%0d: got %h expected %h", tag, lane, lat, cyc, got, exp);
    end
  endtask

  // One clock cycle on the active lane: drive, check at negedge, advance model.
  task automatic step(input bit req, input logic [31:0] a, input bit fl,
                      input bit we, input logic [31:0] wa, input logic [31:0] wd);
    bit          resp, waiting, acc, vld;
    logic [31:0] e_instr;
    @(posedge clk);
    #1;
    fetch_req_a[lane] = req;
    pc_addr_a[lane]   = a;
    flush_a[lane]     = fl;
    wr_en_a[lane]     = we;
    wr_addr_a[lane]   = wa;
    wr_data_a[lane]   = wd;
    @(negedge clk);
    resp    = p_act && (cyc == p_t + lat);
    waiting = p_act && (cyc > p_t) && (cyc < p_t + lat);
    acc     = !p_act && req && !fl;
    vld     = resp && !fl;
    e_instr = vld ? (p_err ? NOPW : p_data) : hold_m;
    chk("stall",       {31'b0, stall_a[lane]},     {31'b0, acc || waiting});
    chk("instr_valid", {31'b0, instr_vld_a[lane]}, {31'b0, vld});
    chk("addr_err",    {31'b0, addr_err_a[lane]},  {31'b0, vld && p_err});
    chk("instr",       instr_a[lane], e_instr);
    last_stall = stall_a[lane];
    if (instr_vld_a[lane] === 1'b1) begin
      seen_cyc   = cyc;
      seen_instr = instr_a[lane];
      seen_err   = addr_err_a[lane];
      n_vld++;
      v_cyc.push_back(cyc);
      v_ins.push_back(instr_a[lane]);
    end
    if (resp) begin
      p_act = 1'b0;
      if (vld) hold_m = e_instr;
    end else if (waiting && fl) begin
      p_act = 1'b0;
    end else if (acc) begin
      p_act = 1'b1;
      p_t   = cyc;
      p_idx = int'((a / 4) % DEPTH);
      p_err = (a % 4 != 0) || (a >= 32'(4 * DEPTH));
    end
    // Data is captured at the edge entering the response, before this cycle's write lands.
    if (p_act && (cyc == p_t + lat - 1)) p_data = mem_m[p_idx];
    if (we && (wa / 4 < DEPTH)) mem_m[wa / 4] = wd;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Fetch one address and let it complete; returns the accept cycle.
  task automatic fetch_one(input logic [31:0] a, output int t0);
    t0 = cyc;
    seen_cyc = -1;
    step(1'b1, a, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(lat + 1);
  endtask

  task automatic reset_mid();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    fetch_req_a[lane] = 1'b1;
    flush_a[lane]     = 1'b0;
    #2;
    chk("rst_stall", {31'b0, stall_a[lane]},     32'h0);
    chk("rst_vld",   {31'b0, instr_vld_a[lane]}, 32'h0);
    chk("rst_err",   {31'b0, addr_err_a[lane]},  32'h0);
    chk("rst_instr", instr_a[lane], 32'h0);
    @(posedge clk);
    #1;
    fetch_req_a[lane] = 1'b0;
    rst_n  = 1'b1;
    p_act  = 1'b0;
    hold_m = 32'h0;
    cyc   += 2;
  endtask

  task automatic run_lane();
    int          t0, nv;
    logic [31:0] pc, a, wa;
    p_act = 1'b0;
    hold_m = 32'h0;
    // Program load.
    for (int w = 0; w < 16; w++) begin
      step(1'b0, 32'h0, 1'b0, 1'b1, 32'(w * 4),
           (w < 4) ? 32'h1111_1111 * 32'(w + 1) : $urandom);
    end

    // Single fetch of word 1.
    fetch_one(32'h4, t0);
    chk("single_lat",  32'(seen_cyc - t0), 32'(lat));
    chk("single_data", seen_instr, 32'h2222_2222);
    chk("single_err",  {31'b0, seen_err}, 32'h0);

    // PC streaming through 0x0, 0x4, 0x8 with advance gated by stall.
    v_cyc.delete();
    v_ins.delete();
    pc = 32'h0;
    for (int k = 0; k < 3 * (lat + 1); k++) begin
      step(1'b1, pc, 1'b0, 1'b0, 32'h0, 32'h0);
      if (!last_stall) pc += 32'h4;
    end
    chk("b2b_count", 32'(v_cyc.size()), 32'd3);
    if (v_cyc.size() == 3) begin
      chk("b2b_i0", v_ins[0], 32'h1111_1111);
      chk("b2b_i1", v_ins[1], 32'h2222_2222);
      chk("b2b_i2", v_ins[2], 32'h3333_3333);
      chk("b2b_gap0", 32'(v_cyc[1] - v_cyc[0]), 32'(lat + 1));
      chk("b2b_gap1", 32'(v_cyc[2] - v_cyc[1]), 32'(lat + 1));
    end

    // Flush while the fetch of 0xC waits.
    if (lat > 1) begin
      nv = n_vld;
      step(1'b1, 32'hC, 1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b0, 32'hC, 1'b1, 1'b0, 32'h0, 32'h0);
      idle(lat + 1);
      chk("flush_wait_novld", 32'(n_vld - nv), 32'h0);
      chk("flush_wait_hold",  instr_a[lane], 32'h3333_3333);
    end

    // Flush in the response cycle.
    nv = n_vld;
    step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(lat - 1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    idle(1);
    chk("flush_resp_novld", 32'(n_vld - nv), 32'h0);
    chk("flush_resp_hold",  instr_a[lane], 32'h3333_3333);

    // Misaligned and out-of-range fetches.
    fetch_one(32'h6, t0);
    chk("misal_lat",   32'(seen_cyc - t0), 32'(lat));
    chk("misal_instr", seen_instr, NOPW);
    chk("misal_err",   {31'b0, seen_err}, 32'h1);
    fetch_one(32'h400, t0);
    chk("oor_lat",   32'(seen_cyc - t0), 32'(lat));
    chk("oor_instr", seen_instr, NOPW);
    chk("oor_err",   {31'b0, seen_err}, 32'h1);

    // Reset in the middle of a fetch: no response may follow.
    step(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
    if (lat > 1) idle(1);
    nv = n_vld;
    reset_mid();
    idle(lat + 2);
    chk("rst_abort_novld", 32'(n_vld - nv), 32'h0);

    // Write to the fetched word on the read edge returns old data.
    t0 = cyc;
    seen_cyc = -1;
    for (int k = 0; k <= lat; k++) begin
      step(k == 0, 32'h8, 1'b0, k == lat - 1, 32'h8, 32'hDEAD_BEEF);
    end
    idle(1);
    chk("rbw_old", seen_instr, 32'h3333_3333);
    fetch_one(32'h8, t0);
    chk("rbw_new", seen_instr, 32'hDEAD_BEEF);

    // Randomised traffic.
    for (int k = 0; k < 300; k++) begin
      a = 32'($urandom_range(15, 0)) * 4;
      case ($urandom_range(9, 0))
        0: a = a + 32'($urandom_range(3, 1));
        1: a = a | (32'h1 << (10 + $urandom_range(21, 0)));
        default: ;
      endcase
      wa = 32'($urandom_range(15, 0)) * 4 + 32'($urandom_range(3, 0));
      if ($urandom_range(7, 0) == 0) wa = wa | 32'h400;
      step($urandom_range(9, 0) < 7, a, $urandom_range(9, 0) == 0,
           $urandom_range(9, 0) < 3, wa, $urandom);
    end
    idle(lat + 1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      fetch_req_a[i] = 1'b0;
      pc_addr_a[i]   = 32'h0;
      flush_a[i]     = 1'b0;
      wr_en_a[i]     = 1'b0;
      wr_addr_a[i]   = 32'h0;
      wr_data_a[i]   = 32'h0;
    end
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
    cyc = 0;
    lat = 0;
    n_vld = 0;
    last_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      lane = i;
      chk("init_stall", {31'b0, stall_a[i]},     32'h0);
      chk("init_vld",   {31'b0, instr_vld_a[i]}, 32'h0);
      chk("init_err",   {31'b0, addr_err_a[i]},  32'h0);
      chk("init_instr", instr_a[i], 32'h0);
    end
    rst_n = 1'b1;
    for (int ln = 0; ln < 3; ln++) begin
      lane = ln;
      lat  = (ln == 0) ? 1 : ((ln == 1) ? 2 : 4);
      run_lane();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
